clk_div_controller: RTL

//   Programmable clock-divider controller. Produces a divided clock (clk_out)
//   and a one-cycle tick at each divided rising edge. Start/stop is driven
//   by en; the divide ratio changes through a req/ack handshake, and a new

---
 rtl/clk_div_controller.sv | 130 +++++++++++++
 1 files changed

// File: rtl/clk_div_controller.sv
// Programmable clock divider: registered divided clock, period-start tick,
// and a req/ack handshake that swaps the divide ratio only at period boundaries.
module clk_div_controller #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             cfg_req,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [DIV_W-1:0] cur_div
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOPPING
    } state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] cnt, cnt_d;
    logic [DIV_W-1:0] cur_div_d;
    logic [DIV_W-1:0] pend_div, pend_div_d;
    logic             pending, pending_d;
    logic             pend_err, pend_err_d;
    logic             clk_out_d, tick_d, ack_d, err_d, running_d;
    logic             boundary, accept, apply;

    // Next-state, counter, config handshake and next output values
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        cur_div_d  = cur_div;
        pend_div_d = pend_div;
        pending_d  = pending;
        pend_err_d = pend_err;
        tick_d     = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        boundary = (state != S_IDLE) && (cnt == cur_div - DIV_W'(1));
        accept   = cfg_req && !pending && !cfg_ack;
        apply    = pending && ((state == S_IDLE) || boundary);

        // accept and apply are mutually exclusive because they disagree on pending
        if (accept) begin
            pending_d = 1'b1;
            if (div_val < DIV_W'(2)) begin
                pend_div_d = DIV_W'(2);
                pend_err_d = 1'b1;
            end else begin
                pend_div_d = div_val;
                pend_err_d = 1'b0;
            end
        end
        if (apply) begin
            pending_d = 1'b0;
            cur_div_d = pend_div;
            ack_d     = 1'b1;
            err_d     = pend_err;
        end

        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = S_RUN;
                    tick_d  = 1'b1;
                end
            end
            S_RUN, S_STOPPING: begin
                if (boundary) begin
                    cnt_d = '0;
                    if (state == S_STOPPING && !en) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = en ? S_RUN : S_STOPPING;
                        tick_d  = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt + DIV_W'(1);
                    state_d = en ? S_RUN : S_STOPPING;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // High phase uses the ratio in effect for the cycle being entered
        running_d = (state_d != S_IDLE);
        clk_out_d = running_d && (cnt_d < (cur_div_d - (cur_div_d >> 1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cur_div  <= DIV_W'(DEFAULT_DIV);
            pend_div <= '0;
            pending  <= 1'b0;
            pend_err <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            cfg_ack  <= 1'b0;
            cfg_err  <= 1'b0;
            running  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            cur_div  <= cur_div_d;
            pend_div <= pend_div_d;
            pending  <= pending_d;
            pend_err <= pend_err_d;
            clk_out  <= clk_out_d;
            tick     <= tick_d;
            cfg_ack  <= ack_d;
            cfg_err  <= err_d;
            running  <= running_d;
        end
    end

endmodule
